// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle control unit for the RV32I core.
// Decodes opcode/func3/func7 into datapath selects, ALU op and memory strobes, and runs a
// load FSM (RST, EXEC, LWAIT, LWB) that holds the PC for LOAD_LAT cycles before write-back.
// Optional feature macro: CTRL_MEM_HS_EN -- load completes on mem_ready, with the counter
// acting as a timeout that suppresses the write-back and flags illegal.
module ctrl_mc #(
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       b,
    input  logic       mem_ready,
    output logic [2:0] imm_type,
    output logic       alu1_sel,
    output logic       alu2_sel,
    output logic [3:0] alu_op,
    output logic [1:0] rd_sel,
    output logic       reg_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [1:0] pc_sel,
    output logic       stall,
    output logic       illegal
);

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_U    = 3'b001;
    localparam logic [2:0] IMM_J    = 3'b010;
    localparam logic [2:0] IMM_S    = 3'b011;
    localparam logic [2:0] IMM_I    = 3'b100;
    localparam logic [2:0] IMM_B    = 3'b101;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] RD_IMM = 2'b00;
    localparam logic [1:0] RD_PC4 = 2'b01;
    localparam logic [1:0] RD_ALU = 2'b10;
    localparam logic [1:0] RD_MEM = 2'b11;

    localparam logic [1:0] PC_ALU   = 2'b00;
    localparam logic [1:0] PC_PLUS4 = 2'b01;
    localparam logic [1:0] PC_HOLD  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {StRst, StExec, StLwait, StLwb} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       alt_f7;
    logic [3:0] arith_op;
    logic [2:0] dec_imm;
    logic       dec_alu1, dec_alu2;
    logic [3:0] dec_alu_op;
    logic [1:0] dec_rd, dec_pc;
    logic       dec_wr, dec_mem_wr, dec_illegal, dec_load;

`ifdef CTRL_MEM_HS_EN
    logic to_q, to_d;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    assign alt_f7 = (func7 == 7'b0100000);

    // ALU op for OP/OP_IMM from func3; func7 picks SUB (OP only) and SRA
    always_comb begin
        arith_op = ALU_ADD;
        case (func3)
            3'b000: arith_op = (alt_f7 && opcode == OPC_OP) ? ALU_SUB : ALU_ADD;
            3'b001: arith_op = ALU_SLL;
            3'b010: arith_op = ALU_SLT;
            3'b011: arith_op = ALU_SLTU;
            3'b100: arith_op = ALU_XOR;
            3'b101: arith_op = alt_f7 ? ALU_SRA : ALU_SRL;
            3'b110: arith_op = ALU_OR;
            3'b111: arith_op = ALU_AND;
        endcase
    end

    // Single-cycle instruction decode, independent of FSM state
    always_comb begin
        dec_imm     = IMM_NONE;
        dec_alu1    = 1'b0;
        dec_alu2    = 1'b0;
        dec_alu_op  = ALU_ADD;
        dec_rd      = RD_ALU;
        dec_wr      = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_pc      = PC_PLUS4;
        dec_illegal = 1'b0;
        dec_load    = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_alu_op = arith_op;
                dec_wr     = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_imm    = IMM_I;
                dec_alu2   = 1'b1;
                dec_alu_op = arith_op;
                dec_wr     = 1'b1;
            end
            OPC_LUI: begin
                dec_imm  = IMM_U;
                dec_alu2 = 1'b1;
                dec_rd   = RD_IMM;
                dec_wr   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_imm  = IMM_U;
                dec_alu1 = 1'b1;
                dec_alu2 = 1'b1;
                dec_wr   = 1'b1;
            end
            OPC_JAL: begin
                dec_imm  = IMM_J;
                dec_alu1 = 1'b1;
                dec_alu2 = 1'b1;
                dec_rd   = RD_PC4;
                dec_wr   = 1'b1;
                dec_pc   = PC_ALU;
            end
            OPC_JALR: begin
                dec_imm  = IMM_I;
                dec_alu2 = 1'b1;
                dec_rd   = RD_PC4;
                dec_wr   = 1'b1;
                dec_pc   = PC_ALU;
            end
            OPC_BRANCH: begin
                dec_imm  = IMM_B;
                dec_alu1 = 1'b1;
                dec_alu2 = 1'b1;
                dec_pc   = b ? PC_ALU : PC_PLUS4;
            end
            OPC_STORE: begin
                dec_imm    = IMM_S;
                dec_alu2   = 1'b1;
                dec_mem_wr = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm  = IMM_I;
                dec_alu2 = 1'b1;
                dec_rd   = RD_MEM;
                dec_load = 1'b1;
            end
            default: begin
                dec_alu2    = 1'b1;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // State and load counter; reset drops any pending write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRst;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CTRL_MEM_HS_EN
    // Remembers that the load timed out so LWB suppresses the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_q <= 1'b0;
        end else begin
            to_q <= to_d;
        end
    end
`endif

    // Next state and outputs; outside EXEC the datapath is pinned to the load shape
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
`ifdef CTRL_MEM_HS_EN
        to_d     = to_q;
`endif
        imm_type = dec_imm;
        alu1_sel = dec_alu1;
        alu2_sel = dec_alu2;
        alu_op   = dec_alu_op;
        rd_sel   = dec_rd;
        reg_wr   = dec_wr;
        mem_rd   = 1'b0;
        mem_wr   = dec_mem_wr;
        pc_sel   = dec_pc;
        stall    = 1'b1;
        illegal  = dec_illegal;
        case (state_q)
            StRst: begin
                reg_wr  = 1'b0;
                mem_wr  = 1'b0;
                pc_sel  = PC_HOLD;
                state_d = StExec;
            end
            StExec: begin
                stall = 1'b0;
                if (dec_load) begin
                    mem_rd = 1'b1;
                    reg_wr = 1'b0;
                    pc_sel = PC_HOLD;
                    cnt_d  = CNT_LOAD;
`ifdef CTRL_MEM_HS_EN
                    if (mem_ready) begin
                        state_d = StLwb;
                    end else if (LOAD_LAT == 1) begin
                        state_d = StLwb;
                        to_d    = 1'b1;
                    end else begin
                        state_d = StLwait;
                    end
`else
                    state_d = (LOAD_LAT == 1) ? StLwb : StLwait;
`endif
                end
            end
            StLwait: begin
                imm_type = IMM_I;
                alu1_sel = 1'b0;
                alu2_sel = 1'b1;
                alu_op   = ALU_ADD;
                rd_sel   = RD_MEM;
                reg_wr   = 1'b0;
                mem_rd   = 1'b1;
                mem_wr   = 1'b0;
                pc_sel   = PC_HOLD;
                illegal  = 1'b0;
                cnt_d    = cnt_q - CNT_ONE;
`ifdef CTRL_MEM_HS_EN
                if (mem_ready) begin
                    state_d = StLwb;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = StLwb;
                    to_d    = 1'b1;
                end
`else
                if (cnt_q == CNT_ONE) begin
                    state_d = StLwb;
                end
`endif
            end
            StLwb: begin
                imm_type = IMM_I;
                alu1_sel = 1'b0;
                alu2_sel = 1'b1;
                alu_op   = ALU_ADD;
                rd_sel   = RD_MEM;
                mem_wr   = 1'b0;
                pc_sel   = PC_PLUS4;
                cnt_d    = '0;
                state_d  = StExec;
`ifdef CTRL_MEM_HS_EN
                reg_wr   = ~to_q;
                illegal  = to_q;
                to_d     = 1'b0;
`else
                reg_wr   = 1'b1;
                illegal  = 1'b0;
`endif
            end
            default: begin
                state_d = StRst;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_mc.sv
// tb_ctrl_mc: drives two ctrl_mc instances (LOAD_LAT 2 and 4) with shared stimulus and
// compares every output field against a cycle-level reference model of the load sequence.
// Honours CTRL_MEM_HS_EN when defined.
module tb_ctrl_mc;

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;

    logic       clk;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       b;
    logic       mem_ready;

    logic [2:0] imm_type [2];
    logic       alu1_sel [2];
    logic       alu2_sel [2];
    logic [3:0] alu_op   [2];
    logic [1:0] rd_sel   [2];
    logic       reg_wr   [2];
    logic       mem_rd   [2];
    logic       mem_wr   [2];
    logic [1:0] pc_sel   [2];
    logic       stall    [2];
    logic       illegal  [2];

    int n_checks;
    int n_pass;
    int cyc_no;

    // Reference model: per instance, in reset / cycles since load issue / write-back cycle
    bit m_rst [2];
    int m_age [2];
    bit m_wb  [2];
    bit m_to  [2];
    int lat   [2];

    ctrl_mc #(.LOAD_LAT(2), .CNT_W(4)) u_dut_l2 (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
        .mem_ready(mem_ready), .imm_type(imm_type[0]), .alu1_sel(alu1_sel[0]),
        .alu2_sel(alu2_sel[0]), .alu_op(alu_op[0]), .rd_sel(rd_sel[0]), .reg_wr(reg_wr[0]),
        .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .pc_sel(pc_sel[0]), .stall(stall[0]),
        .illegal(illegal[0])
    );

    ctrl_mc #(.LOAD_LAT(4), .CNT_W(3)) u_dut_l4 (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
        .mem_ready(mem_ready), .imm_type(imm_type[1]), .alu1_sel(alu1_sel[1]),
        .alu2_sel(alu2_sel[1]), .alu_op(alu_op[1]), .rd_sel(rd_sel[1]), .reg_wr(reg_wr[1]),
        .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .pc_sel(pc_sel[1]), .stall(stall[1]),
        .illegal(illegal[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32 ALU op numbering: ADD SUB SLT SLTU XOR OR AND SLL SRL SRA = 0..9
    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7,
                                           input bit is_op);
        logic [3:0] by_f3 [8];
        by_f3 = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};
        if (f7 == 7'b0100000 && f3 == 3'd5) return 4'd9;
        if (f7 == 7'b0100000 && f3 == 3'd0 && is_op) return 4'd1;
        return by_f3[f3];
    endfunction

    // Expected output vector plus a care mask (fields the behaviour leaves open are masked)
    task automatic ref_out(input int i, output logic [17:0] e, output logic [17:0] m);
        logic [2:0]  imm;
        logic        a1, a2, wr, mr, mw, st, il;
        logic [3:0]  op;
        logic [1:0]  rd, pc;
        logic [10:0] c;  // care bits: imm a1 a2 op rd wr mr mw pc st il
        imm = '0; a1 = 0; a2 = 0; op = '0; rd = '0; pc = '0;
        wr = 0; mr = 0; mw = 0; st = 0; il = 0; c = '0;
        if (m_rst[i]) begin
            pc = 2'b10; st = 1; c = 11'b0_0_0_0_0_1_1_1_1_1_0;
        end else if (m_wb[i]) begin
            rd = 2'b11; wr = !m_to[i]; pc = 2'b01; st = 1; il = m_to[i];
            c = {10'b0_0_0_0_1_1_1_1_1_1, m_to[i]};
        end else if (m_age[i] > 0) begin
            mr = 1; pc = 2'b10; st = 1; c = 11'b0_0_0_0_0_1_1_1_1_1_0;
        end else begin
            case (opcode)
                OPC_OP: begin
                    op = ref_alu(func3, func7, 1); rd = 2'b10; wr = 1; pc = 2'b01;
                    c = 11'b0_0_1_1_1_1_1_1_1_1_1;
                end
                OPC_OP_IMM: begin
                    imm = 3'b100; a2 = 1; op = ref_alu(func3, func7, 0); rd = 2'b10; wr = 1;
                    pc = 2'b01; c = 11'b1_0_1_1_1_1_1_1_1_1_1;
                end
                OPC_LUI: begin
                    imm = 3'b001; rd = 2'b00; wr = 1; pc = 2'b01;
                    c = 11'b1_0_0_1_1_1_1_1_1_1_1;
                end
                OPC_AUIPC: begin
                    imm = 3'b001; a1 = 1; a2 = 1; rd = 2'b10; wr = 1; pc = 2'b01;
                    c = 11'b1_1_1_1_1_1_1_1_1_1_1;
                end
                OPC_JAL: begin
                    imm = 3'b010; a1 = 1; rd = 2'b01; wr = 1; pc = 2'b00;
                    c = 11'b1_1_0_1_1_1_1_1_1_1_1;
                end
                OPC_JALR: begin
                    imm = 3'b100; a1 = 0; rd = 2'b01; wr = 1; pc = 2'b00;
                    c = 11'b1_1_0_1_1_1_1_1_1_1_1;
                end
                OPC_BRANCH: begin
                    imm = 3'b101; a1 = 1; pc = b ? 2'b00 : 2'b01;
                    c = 11'b1_1_0_1_0_1_1_1_1_1_1;
                end
                OPC_STORE: begin
                    imm = 3'b011; a2 = 1; mw = 1; pc = 2'b01;
                    c = 11'b1_0_1_1_0_1_1_1_1_1_1;
                end
                OPC_LOAD: begin
                    imm = 3'b100; a2 = 1; mr = 1; pc = 2'b10;
                    c = 11'b1_0_1_1_0_1_1_1_1_1_1;
                end
                default: begin
                    a2 = 1; pc = 2'b01; il = 1;
                    c = 11'b1_1_1_1_0_1_1_1_1_1_1;
                end
            endcase
        end
        e = {imm, a1, a2, op, rd, wr, mr, mw, pc, st, il};
        m = {{3{c[10]}}, c[9], c[8], {4{c[7]}}, {2{c[6]}}, c[5], c[4], c[3], {2{c[2]}},
             c[1], c[0]};
    endtask

    task automatic m_reset(input int i);
        m_rst[i] = 1; m_age[i] = 0; m_wb[i] = 0; m_to[i] = 0;
    endtask

    // Advance the model by one rising edge using the inputs held during the cycle
    task automatic m_step(input int i);
        if (rst) begin
            m_reset(i);
        end else if (m_rst[i]) begin
            m_rst[i] = 0;
        end else if (m_wb[i]) begin
            m_wb[i] = 0; m_to[i] = 0;
        end else if (m_age[i] == 0) begin
            if (opcode == OPC_LOAD) begin
`ifdef CTRL_MEM_HS_EN
                if (mem_ready) m_wb[i] = 1;
                else if (lat[i] == 1) begin m_wb[i] = 1; m_to[i] = 1; end
                else m_age[i] = 1;
`else
                if (lat[i] == 1) m_wb[i] = 1;
                else m_age[i] = 1;
`endif
            end
        end else begin
`ifdef CTRL_MEM_HS_EN
            if (mem_ready) begin
                m_wb[i] = 1; m_age[i] = 0;
            end else if (m_age[i] == lat[i] - 1) begin
                m_wb[i] = 1; m_age[i] = 0; m_to[i] = 1;
            end else begin
                m_age[i] = m_age[i] + 1;
            end
`else
            if (m_age[i] == lat[i] - 1) begin
                m_wb[i] = 1; m_age[i] = 0;
            end else begin
                m_age[i] = m_age[i] + 1;
            end
`endif
        end
    endtask

    task automatic check_all(input string what);
        logic [17:0] e, m, o;
        for (int i = 0; i < 2; i++) begin
            ref_out(i, e, m);
            o = {imm_type[i], alu1_sel[i], alu2_sel[i], alu_op[i], rd_sel[i], reg_wr[i],
                 mem_rd[i], mem_wr[i], pc_sel[i], stall[i], illegal[i]};
            n_checks = n_checks + 1;
            assert ((o & m) === (e & m)) n_pass = n_pass + 1;
            else $error("FAIL %s lat%0d cycle %0d: observed %h required %h", what, lat[i],
                        cyc_no, o & m, e & m);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, optionally pulse reset mid-cycle
    task automatic cyc(input string what, input logic [4:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic bb, input logic rdy, input logic r,
                       input bit mid_rst);
        @(negedge clk);
        opcode = op; func3 = f3; func7 = f7; b = bb; mem_ready = rdy; rst = r;
        if (r) begin
            m_reset(0); m_reset(1);
        end
        #1;
        check_all(what);
        if (mid_rst) begin
            rst = 1'b1;
            m_reset(0); m_reset(1);
            #1;
            check_all({what, "_async_rst"});
        end
        @(posedge clk);
        m_step(0); m_step(1);
        cyc_no = cyc_no + 1;
    endtask

    logic [4:0] ops [9];
    logic [4:0] r_op;
    logic [6:0] r_f7;

    initial begin
        n_checks = 0; n_pass = 0; cyc_no = 0;
        lat[0] = 2; lat[1] = 4;
        ops = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
                OPC_LUI, OPC_AUIPC};
        rst = 1'b1; opcode = OPC_LOAD; func3 = '0; func7 = '0; b = 1'b0; mem_ready = 1'b0;
        m_reset(0); m_reset(1);

        // Reset held with LOAD presented, then release
        cyc("rst_hold", OPC_LOAD, 3'd0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("rst_hold", OPC_LOAD, 3'd0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("rst_release", OPC_LOAD, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        // Load sequences with opcode held
        for (int k = 0; k < 6; k++) cyc("load_seq", OPC_LOAD, 3'd2, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc("drain", OPC_OP, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Decode sweep
        cyc("lui", OPC_LUI, 3'd3, 7'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("op_imm", OPC_OP_IMM, 3'd4, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("store", OPC_STORE, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("jal", OPC_JAL, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("op_sub", OPC_OP, 3'd0, 7'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("op_sra", OPC_OP, 3'd5, 7'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("op_sltu", OPC_OP, 3'd3, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("opimm_add_f7", OPC_OP_IMM, 3'd0, 7'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("opimm_srai", OPC_OP_IMM, 3'd5, 7'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("illegal", 5'b10101, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("auipc", OPC_AUIPC, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("branch_nt", OPC_BRANCH, 3'd1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("branch_t", OPC_BRANCH, 3'd1, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("jalr", OPC_JALR, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the second LWAIT cycle of the long load: no write-back afterwards
        cyc("ld_issue", OPC_LOAD, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("ld_wait", OPC_LOAD, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("ld_wait2", OPC_LOAD, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("rst_in_load", OPC_STORE, 3'd0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cyc("after_rst", OPC_STORE, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef CTRL_MEM_HS_EN
        // Early completion on mem_ready, then a full timeout
        cyc("hs_issue", OPC_LOAD, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("hs_ready", OPC_LOAD, 3'd2, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("hs_wb", OPC_LOAD, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc("hs_drain", OPC_OP, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc("hs_timeout", OPC_LOAD, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc("hs_drain", OPC_OP, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Randomised traffic, including opcode changes mid-load and stray resets
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) r_op = 5'($urandom);
            else r_op = ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 2))
                0:       r_f7 = 7'h00;
                1:       r_f7 = 7'h20;
                default: r_f7 = 7'($urandom);
            endcase
            cyc("random", r_op, 3'($urandom), r_f7, 1'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
